// File: rtl/mm_job_sched.sv
// Job scheduler for the mm systolic engine: round-robin descriptor grant, size validation,
// shift-add size derivation, run watchdog with soft-reset flush, and completion records.
//
// state | meaning
// IDLE  | wait for a requester, grant round-robin, latch M1/M2/M3
// CALC  | validate sizes, shift-add multiply one bit per cycle
// RUN   | size bus valid, wait for out_D tlast, watchdog running
// FLUSH | hold mm in soft reset after a hang
// DONE  | present completion record until consumed
module mm_job_sched #(
  parameter int NREQ         = 2,
  parameter int N1           = 4,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 24,
  parameter int TIMEOUT_W    = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ*MATRIXSIZE_W-1:0]     req_m1,
  input  logic [NREQ*MATRIXSIZE_W-1:0]     req_m2,
  input  logic [NREQ*MATRIXSIZE_W-1:0]     req_m3,
  output logic [$clog2(NREQ)-1:0]          grant_id,
  output logic                             cfg_valid,
  output logic [MATRIXSIZE_W-1:0]          M2,
  output logic [MATRIXSIZE_W-1:0]          M3,
  output logic [MATRIXSIZE_W-1:0]          M1dN1,
  output logic [MATRIXSIZE_W-1:0]          M3dN2,
  output logic [MATRIXSIZE_W-1:0]          M1xM3dN1,
  output logic [MATRIXSIZE_W-1:0]          M1xM3dN1xN2,
  input  logic                             d_last,
  output logic                             mm_soft_rst,
  output logic                             done_valid,
  input  logic                             done_ready,
  output logic [$clog2(NREQ)-1:0]          done_id,
  output logic [1:0]                       done_err
);

  localparam int W     = MATRIXSIZE_W;
  localparam int ID_W  = $clog2(NREQ);
  localparam int S1    = $clog2(N1);
  localparam int S2    = $clog2(N2);
  localparam int TMR_W = ($clog2(W) > 2) ? $clog2(W) : 2;

  localparam logic [W-1:0]         MASK1   = W'(N1 - 1);
  localparam logic [W-1:0]         MASK2   = W'(N2 - 1);
  localparam logic [TIMEOUT_W-1:0] WD_ONES = '1;
  localparam logic [TIMEOUT_W-1:0] WD_LOAD = WD_ONES - TIMEOUT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, pick;
  logic               any_req;
  int                 idx;
  logic [W-1:0]       sel_m1, sel_m2, sel_m3;
  logic [W-1:0]       m1_r, m2_r, m3_r;
  logic [2*W-1:0]     acc, acc_nxt, mcd;
  logic [W-1:0]       mpl;
  logic [TMR_W-1:0]   tmr;
  logic [TIMEOUT_W-1:0] wd;
  logic [1:0]         err_r;
  logic               size_ok, ovf;

  // First requesting slot strictly after the last grant, wrapping.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        pick    = ID_W'(idx);
      end
    end
  end

  assign sel_m1 = req_m1[int'(pick)*W +: W];
  assign sel_m2 = req_m2[int'(pick)*W +: W];
  assign sel_m3 = req_m3[int'(pick)*W +: W];

  assign size_ok = (m1_r != '0) && (m2_r != '0) && (m3_r != '0) &&
                   ((m1_r & MASK1) == '0) && ((m3_r & MASK2) == '0);
  assign acc_nxt = acc + (mpl[0] ? mcd : '0);
  // Covers both the product overflow and the P<<log2(N2) overflow.
  assign ovf     = (acc_nxt >> (W - S2)) != '0;

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    cfg_valid   = 1'b0;
    mm_soft_rst = 1'b0;
    done_valid  = 1'b0;
    done_id     = '0;
    done_err    = 2'b00;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_CALC;
          if (!rst) req_ready = NREQ'(1) << pick;
        end
      end
      S_CALC: begin
        if (!size_ok)        state_nxt = S_DONE;
        else if (tmr == '0)  state_nxt = ovf ? S_DONE : S_RUN;
      end
      S_RUN: begin
        cfg_valid = 1'b1;
        if (d_last)          state_nxt = S_DONE;
        else if (wd == '0)   state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        mm_soft_rst = 1'b1;
        if (tmr == '0)       state_nxt = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_id    = grant_id;
        done_err   = err_r;
        if (done_ready)      state_nxt = S_IDLE;
      end
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= ID_W'(NREQ - 1);
      grant_id    <= '0;
      m1_r        <= '0;
      m2_r        <= '0;
      m3_r        <= '0;
      acc         <= '0;
      mcd         <= '0;
      mpl         <= '0;
      tmr         <= '0;
      wd          <= '0;
      err_r       <= 2'b00;
      M2          <= '0;
      M3          <= '0;
      M1dN1       <= '0;
      M3dN2       <= '0;
      M1xM3dN1    <= '0;
      M1xM3dN1xN2 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            ptr      <= pick;
            grant_id <= pick;
            m1_r     <= sel_m1;
            m2_r     <= sel_m2;
            m3_r     <= sel_m3;
            acc      <= '0;
            mcd      <= {{W{1'b0}}, (sel_m1 >> S1)};
            mpl      <= sel_m3 >> S2;
            tmr      <= TMR_W'(W - 1);
            err_r    <= 2'b00;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          mcd <= mcd << 1;
          mpl <= mpl >> 1;
          tmr <= tmr - TMR_W'(1);
          if (!size_ok) begin
            err_r <= 2'b01;
          end else if (tmr == '0) begin
            if (ovf) begin
              err_r <= 2'b01;
            end else begin
              M2          <= m2_r;
              M3          <= m3_r;
              M1dN1       <= m1_r >> S1;
              M3dN2       <= m3_r >> S2;
              M1xM3dN1xN2 <= acc_nxt[W-1:0];
              M1xM3dN1    <= acc_nxt[W-1:0] << S2;
              wd          <= WD_LOAD;
            end
          end
        end
        S_RUN: begin
          if (d_last) begin
            wd <= WD_LOAD;
          end else if (wd == '0) begin
            tmr   <= TMR_W'(3);
            err_r <= 2'b10;
          end else begin
            wd <= wd - TIMEOUT_W'(1);
          end
        end
        S_FLUSH: tmr <= tmr - TMR_W'(1);
        default: ;
      endcase
    end
  end

endmodule
